program_loader: RTL and testbench

Boot-time program loader: writes a program image into the processor's 1024 x 16-bit instruction memory from a byte stream with a valid/ready handshake. Sits between a host byte source (UART receiver or test harness) and the instruction-memory write port. Holds the processor in reset while a load is in progress. Releases it once the final word is committed.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package loader_pkg;

    localparam int unsigned LOADER_LEN_BYTES = 2;
    localparam int unsigned DATA_BYTES       = 2;

    typedef enum logic [3:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
`ifdef LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
import loader_pkg::*;

module program_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned LenW = LOADER_LEN_BYTES * 8;
    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam int unsigned HiW  = (DATA_BYTES - 1) * 8;
    localparam logic [LenW-1:0] MaxLen = LenW'(2 ** ADDR_WIDTH);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e StFinal = StCheck;
`else
    localparam loader_state_e StFinal = StDone;
`endif

    loader_state_e         state_q, state_d;
    logic [LenW-1:0]       len_q, len_d;
    logic [HiW-1:0]        hi_q, hi_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  byte_fire;
    logic                  start_ok;
    logic [LenW-1:0]       len_in;
    logic [CntW-1:0]       cnt_inc;

    assign byte_fire = in_valid && in_ready;
    assign start_ok  = start && (state_q inside {StIdle, StDone, StError});
    assign len_in    = LenW'({hi_q, in_data});
    assign cnt_inc   = cnt_q + CntW'(1);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       csum_ok;

    // Accumulate every length and data byte; the checksum byte itself is excluded.
    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (byte_fire && state_q != StCheck) begin
            csum_d = csum_q ^ in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign csum_ok = (in_data == csum_q);
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_ok) begin
                    state_d = StLenHi;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            StLenHi: begin
                in_ready = 1'b1;
                if (byte_fire) begin
                    hi_d    = HiW'(in_data);
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                in_ready = 1'b1;
                if (byte_fire) begin
                    len_d = len_in;
                    if (len_in > MaxLen)     state_d = StError;
                    else if (len_in == '0)   state_d = StFinal;
                    else                     state_d = StDataHi;
                end
            end
            StDataHi: begin
                in_ready = 1'b1;
                if (byte_fire) begin
                    hi_d    = HiW'(in_data);
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                in_ready = 1'b1;
                if (byte_fire) begin
                    wdata_d = DATA_WIDTH'({hi_q, in_data});
                    state_d = StWrite;
                end
            end
            StWrite: begin
                mem_we = 1'b1;
                cnt_d  = cnt_inc;
                // Wraps to 0 only after word 1023 of a full-depth image; no write follows.
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (LenW'(cnt_inc) < len_q) state_d = StDataHi;
                else                        state_d = StFinal;
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                in_ready = 1'b1;
                if (byte_fire) state_d = csum_ok ? StDone : StError;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = !(state_q inside {StIdle, StDone});
    assign busy      = !(state_q inside {StIdle, StDone, StError});
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, busy, done, error;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int consumed = 0;
    int wr_base, cons_base;
    logic [7:0]  csum;
    logic [15:0] mem_model [1024];

    program_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Observe just before each rising edge, when every signal has settled.
    always @(negedge clk) begin
        #4;
        if (in_valid && in_ready) consumed++;
        if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wr_count++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Present a byte and return on the negedge after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        csum     = csum ^ b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        csum  = 8'h00;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; csum = 8'h00;
        foreach (mem_model[i]) mem_model[i] = 16'h0000;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Two-word image, valid held high
        do_start();
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        check("w0_we", 32'(mem_we), 32'd1);
        check("w0_addr", 32'(mem_addr), 32'd0);
        check("w0_data", 32'(mem_wdata), 32'h1234);
        send_byte(8'hAB); send_byte(8'hCD);
        check("w1_we", 32'(mem_we), 32'd1);
        check("w1_addr", 32'(mem_addr), 32'd1);
        check("w1_data", 32'(mem_wdata), 32'hABCD);
`ifdef LOADER_CHECKSUM_EN
        check("csum_two_word", 32'(csum), 32'h42);
        send_byte(8'h42);
`else
        @(negedge clk);
`endif
        in_valid = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_error", 32'(error), 32'd0);
        check("t1_writes", 32'(wr_count), 32'd2);

        // Zero length
        wr_base = wr_count;
        do_start();
        check("zero_done_cleared", 32'(done), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        in_valid = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        check("zero_writes", 32'(wr_count - wr_base), 32'd0);

        // Oversize length 1025
        do_start();
        send_byte(8'h04); send_byte(8'h01);
        check("over_error", 32'(error), 32'd1);
        check("over_cpu_hold", 32'(cpu_hold), 32'd1);
        check("over_done", 32'(done), 32'd0);
        cons_base = consumed;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("over_not_consumed", 32'(consumed - cons_base), 32'd0);
        check("over_hold_kept", 32'(cpu_hold), 32'd1);
        check("over_writes", 32'(wr_count - wr_base), 32'd0);

        // Two-word image, valid toggling, start pulsed mid-session
        mem_model[0] = 16'h0000; mem_model[1] = 16'h0000;
        wr_base = wr_count;
        do_start();
        cons_base = consumed;
        check("err_cleared", 32'(error), 32'd0);
        in_valid = 1'b0; @(negedge clk); send_byte(8'h00);
        in_valid = 1'b0; @(negedge clk); send_byte(8'h02);
        in_valid = 1'b0; @(negedge clk); send_byte(8'h12);
        in_valid = 1'b0; start = 1'b1; @(negedge clk); send_byte(8'h34); start = 1'b0;
        in_valid = 1'b0; @(negedge clk); send_byte(8'hAB);
        in_valid = 1'b0; @(negedge clk); send_byte(8'hCD);
`ifdef LOADER_CHECKSUM_EN
        in_valid = 1'b0; @(negedge clk); send_byte(8'h42);
        check("tog_consumed", 32'(consumed - cons_base), 32'd7);
`else
        in_valid = 1'b0; @(negedge clk);
        check("tog_consumed", 32'(consumed - cons_base), 32'd6);
`endif
        in_valid = 1'b0;
        check("tog_done", 32'(done), 32'd1);
        check("tog_writes", 32'(wr_count - wr_base), 32'd2);
        check("tog_mem0", 32'(mem_model[0]), 32'h1234);
        check("tog_mem1", 32'(mem_model[1]), 32'hABCD);

        // Reset during DATA_LO of word 1, then reload
        do_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_in_ready_rst", 32'(in_ready), 32'd0);
        check("mid_we_rst", 32'(mem_we), 32'd0);
        check("mid_addr_rst", 32'(mem_addr), 32'd0);
        check("mid_wdata_rst", 32'(mem_wdata), 32'd0);
        check("mid_hold_rst", 32'(cpu_hold), 32'd0);
        check("mid_busy_rst", 32'(busy), 32'd0);
        check("mid_done_rst", 32'(done), 32'd0);
        check("mid_error_rst", 32'(error), 32'd0);
        do_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
        check("reload_addr", 32'(mem_addr), 32'd0);
        check("reload_data", 32'(mem_wdata), 32'h5566);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h32);
`else
        @(negedge clk);
`endif
        in_valid = 1'b0;
        check("reload_done", 32'(done), 32'd1);

        // Full-depth image of 1024 words, word i holds i
        wr_base = wr_count;
        do_start();
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            send_byte(8'(i >> 8));
            send_byte(8'(i));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum);
`else
        @(negedge clk);
`endif
        in_valid = 1'b0;
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_writes", 32'(wr_count - wr_base), 32'd1024);
        check("full_mem0", 32'(mem_model[0]), 32'h0000);
        check("full_mem1023", 32'(mem_model[1023]), 32'h03FF);
        check("full_addr_wrap", 32'(mem_addr), 32'd0);
        @(negedge clk);
        check("full_no_extra_write", 32'(wr_count - wr_base), 32'd1024);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h27);
        in_valid = 1'b0;
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_error", 32'(error), 32'd0);
        do_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h00);
        in_valid = 1'b0;
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_hold", 32'(cpu_hold), 32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
